// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_div_unit                                              |
// | Description : Iterative HI/LO multiply/divide unit with pipeline stall.  |
// |               Optional signed MULT/DIV (codes 13/14): SIGNED_MULDIV_EN   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       control_input,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] result_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fin  = 2'd3;

    localparam logic [3:0] c_op_mult = 4'd8;
    localparam logic [3:0] c_op_div  = 4'd9;
    localparam logic [3:0] c_op_mfhi = 4'd11;
    localparam logic [3:0] c_op_mflo = 4'd12;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state, w_next_state;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_op;   // multiplicand or divisor
    logic [WIDTH-1:0] r_mq;   // multiplier/product-low or dividend/quotient
    logic [WIDTH-1:0] r_acc;  // product-high or partial remainder
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_by_zero;

    logic             w_is_mul, w_is_div, w_idle, w_last, w_div_zero_in;
    logic             w_issue_mul, w_issue_div, w_dbz;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum, w_shift;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_sub, w_div_rem, w_div_quo, w_ge_vec;
    logic             w_ge;
    logic [WIDTH-1:0] w_mul_hi_fin, w_mul_lo_fin, w_div_hi_fin, w_div_lo_fin;

`ifdef SIGNED_MULDIV_EN
    localparam logic [3:0] c_op_mults = 4'd13;
    localparam logic [3:0] c_op_divs  = 4'd14;

    logic               w_signed;
    logic               r_neg_q, r_neg_r;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = (control_input == c_op_mults) || (control_input == c_op_divs);
    assign w_is_mul = (control_input == c_op_mult) || (control_input == c_op_mults);
    assign w_is_div = (control_input == c_op_div) || (control_input == c_op_divs);
    assign w_a_mag  = (w_signed && input_1[WIDTH-1]) ? -input_1 : input_1;
    assign w_b_mag  = (w_signed && input_2[WIDTH-1]) ? -input_2 : input_2;

    // Results come out of the unsigned datapath as magnitudes; apply signs on write-back
    assign w_prod = {w_mul_hi, w_mul_lo};
    assign {w_mul_hi_fin, w_mul_lo_fin} = r_neg_q ? -w_prod : w_prod;
    assign w_div_lo_fin = r_neg_q ? -w_div_quo : w_div_quo;
    assign w_div_hi_fin = r_neg_r ? -w_div_rem : w_div_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_issue_mul || w_issue_div) begin
            r_neg_q <= w_signed & (input_1[WIDTH-1] ^ input_2[WIDTH-1]);
            r_neg_r <= w_signed & w_is_div & input_1[WIDTH-1];
        end
    end
`else
    assign w_is_mul     = (control_input == c_op_mult);
    assign w_is_div     = (control_input == c_op_div);
    assign w_a_mag      = input_1;
    assign w_b_mag      = input_2;
    assign w_mul_hi_fin = w_mul_hi;
    assign w_mul_lo_fin = w_mul_lo;
    assign w_div_hi_fin = w_div_rem;
    assign w_div_lo_fin = w_div_quo;
`endif

    assign w_idle        = (r_state == c_st_idle);
    assign w_last        = (r_cnt == c_last);
    assign w_div_zero_in = (input_2 == '0);
    assign w_issue_mul   = w_idle & valid_in & w_is_mul;
    assign w_issue_div   = w_idle & valid_in & w_is_div & ~w_div_zero_in;
    assign w_dbz         = w_idle & valid_in & w_is_div & w_div_zero_in;

    // Shift-add step: {acc, mq} holds the running product, shifted right once per cycle
    assign w_sum    = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_op} : '0);
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_mq[WIDTH-1:1]};

    // Restoring step: the remainder stays below the divisor so WIDTH bits suffice
    assign w_shift   = {r_acc, r_mq[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_op});
    assign w_sub     = w_shift[WIDTH-1:0] - r_op;
    assign w_ge_vec  = {WIDTH{w_ge}};
    assign w_div_rem = (w_ge_vec & w_sub) | (~w_ge_vec & w_shift[WIDTH-1:0]);
    assign w_div_quo = {r_mq[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_issue_mul)      w_next_state = c_st_mul;
                else if (w_issue_div) w_next_state = c_st_div;
            end
            c_st_mul:  if (w_last) w_next_state = c_st_fin;
            c_st_div:  if (w_last) w_next_state = c_st_fin;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi          <= '0;
            r_lo          <= '0;
            r_op          <= '0;
            r_mq          <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_div_by_zero <= w_dbz;
            case (r_state)
                c_st_idle: begin
                    if (w_issue_mul) begin
                        r_op  <= w_a_mag;
                        r_mq  <= w_b_mag;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else if (w_issue_div) begin
                        r_op  <= w_b_mag;
                        r_mq  <= w_a_mag;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                c_st_mul: begin
                    r_acc <= w_mul_hi;
                    r_mq  <= w_mul_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_mul_hi_fin;
                        r_lo <= w_mul_lo_fin;
                    end
                end
                c_st_div: begin
                    r_acc <= w_div_rem;
                    r_mq  <= w_div_quo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_div_hi_fin;
                        r_lo <= w_div_lo_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == c_st_mul) || (r_state == c_st_div);
    assign done        = (r_state == c_st_fin);
    assign div_by_zero = r_div_by_zero;
    assign stall       = busy | w_issue_mul | w_issue_div;

    always_comb begin
        result_out = '0;
        if (control_input == c_op_mfhi)      result_out = r_hi;
        else if (control_input == c_op_mflo) result_out = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mult_div_unit                                           |
// | Description : Self-checking bench for mult_div_unit (vectors+scoreboard) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk, reset, valid_in;
    logic [3:0]  control_input;
    logic [31:0] input_1, input_2, result_out;
    logic        busy, done, div_by_zero, stall;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   n_ops   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .control_input(control_input),
        .input_1(input_1), .input_2(input_2), .result_out(result_out), .busy(busy),
        .done(done), .div_by_zero(div_by_zero), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) n_done++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in      = 1'b0;
        control_input = 4'd0;
        input_1       = '0;
        input_2       = '0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = 4'd11;
        #1 check({tag, "_mfhi"}, result_out, hi);
        check({tag, "_mfhi_stall"}, stall, 0);
        @(posedge clk); #1;
        control_input = 4'd12;
        #1 check({tag, "_mflo"}, result_out, lo);
        idle_inputs();
    endtask

    // Issue one op, hold it while stalled, then read HI/LO back
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        int   lat, stall_cnt;
        bit   seen;
        exp_t e;
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = code; input_1 = a; input_2 = b;
        #1 check("issue_stall", stall, 1);
        sb.push_back('{hi: hi, lo: lo});
        n_ops++;
        @(posedge clk); #1;
        lat = 0; stall_cnt = 0; seen = 0;
        while (lat < WIDTH + 4) begin
            if (done) begin seen = 1; break; end
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", seen, 1);
        check("latency", lat, WIDTH);
        check("stall_cycles", stall_cnt, WIDTH);
        check("fin_stall", stall, 0);
        check("fin_busy", busy, 0);
        e = '{hi: 32'hDEAD_BEEF, lo: 32'hDEAD_BEEF};
        if (sb.size() > 0) e = sb.pop_front();
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        valid_in = 1'b1; control_input = 4'd11;
        #1 check("op_hi", result_out, e.hi);
        @(posedge clk); #1;
        control_input = 4'd12;
        #1 check("op_lo", result_out, e.lo);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        read_hilo("rst", 32'h0, 32'h0);

        vecs[0] = '{code: 4'd8, a: 32'h0001_0000, b: 32'h0001_0000, hi: 32'h0000_0001, lo: 32'h0000_0000};
        vecs[1] = '{code: 4'd8, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
        vecs[2] = '{code: 4'd8, a: 32'h0000_0000, b: 32'h1234_5678, hi: 32'h0000_0000, lo: 32'h0000_0000};
        vecs[3] = '{code: 4'd9, a: 32'hFFFF_FFFF, b: 32'h0000_0001, hi: 32'h0000_0000, lo: 32'hFFFF_FFFF};
        vecs[4] = '{code: 4'd9, a: 32'd7,         b: 32'd9,         hi: 32'd7,         lo: 32'd0};
        vecs[5] = '{code: 4'd9, a: 32'd100,       b: 32'd7,         hi: 32'd2,         lo: 32'd14};
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Divide by zero: no stall, single pulse, HI/LO keep 2/14
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = 4'd9; input_1 = 32'd5; input_2 = 32'd0;
        #1 check("dbz_stall", stall, 0);
        @(posedge clk); #1;
        idle_inputs();
        check("dbz_pulse", div_by_zero, 1);
        check("dbz_busy", busy, 0);
        @(posedge clk); #1;
        check("dbz_pulse_end", div_by_zero, 0);
        read_hilo("dbz", 32'd2, 32'd14);

        // Reset during a DIV abandons it
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = 4'd9; input_1 = 32'd1000; input_2 = 32'd3;
        repeat (5) @(posedge clk);
        #1 control_input = 4'd11;
        #1 check("busy_mfhi_stale", result_out, 32'd2);
        check("busy_mfhi_stall", stall, 1);
        check("busy_mid", busy, 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        idle_inputs();
        #1 check("rst_mid_busy", busy, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_done", done, 0);
        @(posedge clk); #1 reset = 1'b0;
        read_hilo("rst_mid", 32'h0, 32'h0);
        run_op(4'd8, 32'd3, 32'd4, 32'd0, 32'd12);

        // Randomised operands checked against native wide arithmetic
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            logic [63:0] p;
            a = $urandom;
            b = $urandom;
            p = 64'(a) * 64'(b);
            run_op(4'd8, a, b, p[63:32], p[31:0]);
            b = $urandom_range(1, 65536);
            run_op(4'd9, a, b, a % b, a / b);
        end

        // Codes outside the unit's set do nothing
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = 4'd5; input_1 = 32'd9; input_2 = 32'd9;
        #1 check("other_stall", stall, 0);
        check("other_result", result_out, 0);
        @(posedge clk); #1;
        check("other_busy", busy, 0);
        idle_inputs();

`ifdef SIGNED_MULDIV_EN
        run_op(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(4'd13, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
        @(posedge clk); #1;
        valid_in = 1'b1; control_input = 4'd13; input_1 = 32'hFFFF_FFFD; input_2 = 32'd4;
        #1 check("unsig13_stall", stall, 0);
        check("unsig13_result", result_out, 0);
        @(posedge clk); #1;
        check("unsig13_busy", busy, 0);
        control_input = 4'd14;
        #1 check("unsig14_stall", stall, 0);
        idle_inputs();
`endif

        repeat (2) @(posedge clk);
        #1 check("sb_empty", sb.size(), 0);
        check("done_count", n_done, n_ops);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit in the EX stage, beside the ALU. It owns the architectural HI and LO registers. It executes MULT and DIV over multiple cycles, serves MFHI and MFLO reads, and raises a stall so the pipeline front end holds while an operation is in flight. It uses the same 4-bit ALU control encoding: 8=MULT, 9=DIV, 11=MFHI, 12=MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
valid_in  input  1  EX stage holds a valid instruction this cycle
control_input  input  4  ALU control code from ID/EX
input_1  input  WIDTH  rs operand (dividend / multiplicand)
input_2  input  WIDTH  rt operand (divisor / multiplier)
result_out  output  WIDTH  HI for code 11, LO for code 12, else 0
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO are written
div_by_zero  output  1  one-cycle pulse when DIV is issued with input_2 == 0
stall  output  1  combinational hold request to the PC, IF/ID and ID/EX registers

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; HI=0; LO=0; counter=0; busy=0; done=0; div_by_zero=0. Reset mid-operation abandons the operation and HI/LO read 0 afterwards.
- States: IDLE, MUL, DIV, FIN.
- IDLE, valid_in & code 8: latch operands, acc={WIDTH{0}}, counter=0, go to MUL.
- IDLE, valid_in & code 9 & input_2!=0: latch operands, remainder=0, go to DIV.
- IDLE, valid_in & code 9 & input_2==0: stay IDLE. HI/LO unchanged, div_by_zero pulses next cycle, no stall.
- MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles. On the last iteration write {HI,LO}=input_1*input_2 (full 2*WIDTH product), then go to FIN.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles. On completion LO=quotient, HI=remainder, then go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency: issue edge E. HI/LO are written at edge E+WIDTH and done is high during cycle E+WIDTH to E+WIDTH+1. MFHI/MFLO in the cycle after done returns the new value.
- busy=1 in MUL and DIV; 0 in IDLE and FIN.
- stall=1 in each of these cases:
  - the issue cycle of a MULT/DIV (IDLE with valid code 8, or code 9 with nonzero divisor);
  - all MUL/DIV cycles.
  The pipeline releases in FIN. The issuing instruction leaves EX once FIN is reached; it is held in EX while the unit is busy, and the unit ignores re-presented codes while busy.
- MFHI/MFLO while busy: stall stays 1 and result_out is driven from HI/LO (stale value, not consumed since the stage is held). When FIN arrives, stall drops and result_out shows the new HI/LO combinationally.
- The FSM does not re-accept the same held instruction: issue occurs only from IDLE. FIN returns to IDLE, and the next cycle's instruction is new because stall has dropped.
- Other control codes: no effect; result_out=0.
- HI/LO are modified only by a completed MULT/DIV or by reset.

Optional Feature:
SIGNED_MULDIV_EN. When defined, codes 13 (MULT signed) and 14 (DIV signed) are also accepted:
- operands are converted to magnitudes, the unsigned datapath is reused, and results are negated at FIN;
- product sign = sign(a) XOR sign(b);
- quotient sign = sign(a) XOR sign(b); remainder takes the dividend's sign;
- most-negative / -1 yields LO=most-negative, HI=0.
When undefined, codes 13/14 behave as "other codes": no issue, no stall, result_out=0.

Test Plan:
- MULT 0x0001_0000 * 0x0001_0000, then MFHI/MFLO after done -> HI=0x0000_0001, LO=0x0000_0000; done exactly 32 cycles after issue; stall high 32 cycles.
- DIV 100 / 7, then MFLO/MFHI -> LO=14, HI=2; busy for 32 cycles; one done pulse.
- DIV 5 / 0 with HI=2, LO=14 prior -> no stall, div_by_zero pulses once, HI/LO stay 2/14.
- MULT 0xFFFF_FFFF * 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- Assert reset at cycle 10 of a DIV -> busy, stall, done drop immediately; MFHI/MFLO return 0; a new MULT 3*4 gives LO=12.
- With SIGNED_MULDIV_EN: code 14, -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); code 13, -3 * 4 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFF4.
